// File: rtl/counter_checker.sv
// Up/down counter checker: predicts the next count, flags mismatches and wraps, tracks lock and errors.
// Latency: mismatch/wrap/err_count 1 cycle after a vld sample. No backpressure; every vld sample is consumed.
module counter_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic             mod,
    input  logic [WIDTH-1:0] count,
    input  logic             clr_err,
    output logic [WIDTH-1:0] exp_count,
    output logic             mismatch,
    output logic             wrap,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   model_q, model_d;
    logic               mod_q, mod_d;
    logic [7:0]         run_q, run_d;
    logic               mismatch_q, mismatch_d;
    logic               wrap_q, wrap_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic [WIDTH-1:0]   pred;
    logic               hit;
    logic [7:0]         run_inc;

    always_comb begin
        state_d    = state_q;
        model_d    = model_q;
        mod_d      = mod_q;
        run_d      = run_q;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        err_d      = err_q;
        // Direction from the previous sample: the counter applies mod on the following edge.
        pred       = mod_q ? model_q + WIDTH'(1) : model_q - WIDTH'(1);
        hit        = (count == pred);
        run_inc    = run_q + 8'd1;

        if (vld) begin
            model_d = count;
            mod_d   = mod;
            if (state_q == SEED) begin
                state_d = TRACK;
            end else if (hit) begin
                // A hit already pins count, so only the model end needs testing.
                wrap_d = (mod_q && (model_q == {WIDTH{1'b1}})) ||
                         (!mod_q && (model_q == {WIDTH{1'b0}}));
                if (state_q == TRACK) begin
                    run_d = run_inc;
                    if (run_inc == 8'(LOCK_CNT)) begin
                        state_d = LOCKED;
                    end
                end
            end else begin
                mismatch_d = 1'b1;
                run_d      = 8'd0;
                state_d    = TRACK;
                if (err_q != {ERR_W{1'b1}}) begin
                    err_d = err_q + ERR_W'(1);
                end
            end
        end

        if (clr_err) begin
            err_d = '0;
        end

        exp_count = (state_q == SEED) ? '0 : pred;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SEED;
            model_q    <= '0;
            mod_q      <= 1'b0;
            run_q      <= 8'd0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            model_q    <= model_d;
            mod_q      <= mod_d;
            run_q      <= run_d;
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
        end
    end

    assign mismatch  = mismatch_q;
    assign wrap      = wrap_q;
    assign locked    = (state_q == LOCKED);
    assign err_count = err_q;

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboarded bench for counter_checker: driver pushes predicted outputs, monitor pops and compares each cycle.
module tb_counter_checker;

    localparam int W   = 4;
    localparam int LC  = 4;
    localparam int EW  = 8;
    localparam int MOD = 1 << W;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic          mod;
    logic [W-1:0]  count;
    logic          clr_err;
    logic [W-1:0]  exp_count;
    logic          mismatch;
    logic          wrap;
    logic          locked;
    logic [EW-1:0] err_count;

    counter_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .mod       (mod),
        .count     (count),
        .clr_err   (clr_err),
        .exp_count (exp_count),
        .mismatch  (mismatch),
        .wrap      (wrap),
        .locked    (locked),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  ec;
        logic          mis;
        logic          wr;
        logic          lk;
        logic [EW-1:0] err;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: last seen value/direction, run length, lock flag, error tally.
    bit m_seeded;
    int m_prev;
    int m_dir;
    int m_run;
    bit m_lk;
    int m_err;

    function automatic int nxt(input int v, input int d);
        return (v + (d != 0 ? 1 : MOD - 1)) % MOD;
    endfunction

    task automatic compare(input string name, input obs_t e);
        obs_t g;
        g = {exp_count, mismatch, wrap, locked, err_count};
        checks++;
        if (g === e) passes++;
        else $display("FAIL %s t=%0t: got exp_count=%0d mismatch=%0b wrap=%0b locked=%0b err_count=%0d, want exp_count=%0d mismatch=%0b wrap=%0b locked=%0b err_count=%0d",
                      name, $time, g.ec, g.mis, g.wr, g.lk, g.err, e.ec, e.mis, e.wr, e.lk, e.err);
    endtask

    function automatic void model_reset();
        m_seeded = 0; m_prev = 0; m_dir = 0; m_run = 0; m_lk = 0; m_err = 0;
    endfunction

    function automatic obs_t model_step(input bit v, input bit m, input int c, input bit clr);
        obs_t e;
        bit mis = 0;
        bit wr  = 0;
        if (v) begin
            if (!m_seeded) begin
                m_seeded = 1;
            end else if (c == nxt(m_prev, m_dir)) begin
                m_run++;
                if (m_run >= LC) m_lk = 1;
                wr = (m_dir != 0 && m_prev == MOD - 1 && c == 0) ||
                     (m_dir == 0 && m_prev == 0 && c == MOD - 1);
            end else begin
                mis   = 1;
                m_run = 0;
                m_lk  = 0;
                m_err = (m_err < EMAX) ? m_err + 1 : EMAX;
            end
            m_prev = c;
            m_dir  = m;
        end
        if (clr) m_err = 0;
        e.ec  = m_seeded ? W'(nxt(m_prev, m_dir)) : '0;
        e.mis = mis;
        e.wr  = wr;
        e.lk  = m_lk;
        e.err = EW'(m_err);
        return e;
    endfunction

    task automatic step(input bit v, input bit m, input int c, input bit clr);
        @(negedge clk);
        rst     = 1'b1;
        vld     = v;
        mod     = m;
        count   = W'(c);
        clr_err = clr;
        exp_q.push_back(model_step(v, m, c % MOD, clr));
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b0;
        vld = 1'b0;
        clr_err = 1'b0;
        #1;
        model_reset();
        compare(name, '0);
        exp_q.push_back('0);
    endtask

    // Monitor: outputs are presented every cycle, so one expectation is consumed per edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) compare("cycle", exp_q.pop_front());
    end

    initial begin
        int up_seq[6];
        int wrap_up[5];
        int wrap_dn[4];
        int inj[9];
        rst = 1'b0; vld = 1'b0; mod = 1'b0; count = '0; clr_err = 1'b0;
        model_reset();
        #1;
        compare("reset_state", '0);
        repeat (2) @(negedge clk);

        up_seq = '{0, 1, 2, 3, 4, 5};
        foreach (up_seq[i]) step(1, 1, up_seq[i], 0);

        do_reset("reset_before_upwrap");
        wrap_up = '{13, 14, 15, 0, 1};
        foreach (wrap_up[i]) step(1, 1, wrap_up[i], 0);

        do_reset("reset_before_dnwrap");
        wrap_dn = '{2, 1, 0, 15};
        foreach (wrap_dn[i]) step(1, 0, wrap_dn[i], 0);

        do_reset("reset_before_inject");
        for (int i = 0; i <= 4; i++) step(1, 1, i, 0);
        inj = '{5, 6, 7, 8, 11, 12, 13, 14, 15};
        foreach (inj[i]) step(1, 1, inj[i], 0);

        do_reset("reset_before_flip");
        step(1, 1, 5, 0);
        step(1, 0, 6, 0);
        step(1, 0, 5, 0);
        step(1, 0, 4, 0);

        do_reset("reset_before_gaps");
        step(1, 1, 3, 0);
        step(1, 1, 4, 0);
        for (int i = 0; i < 5; i++) step(0, $urandom % 2, $urandom % MOD, 0);
        step(1, 1, 5, 0);

        do_reset("reset_before_sat");
        step(1, 1, 0, 0);
        for (int i = 1; i <= 300; i++) step(1, 1, (2 * i) % MOD, 0);
        step(1, 1, (m_prev + 5) % MOD, 1);
        step(1, 1, nxt(m_prev, m_dir), 0);

        do_reset("reset_before_random");
        for (int i = 0; i < 600; i++) begin
            bit v   = ($urandom % 4) != 0;
            bit m   = $urandom % 2;
            bit bad = ($urandom % 10) == 0;
            bit clr = ($urandom % 25) == 0;
            int c   = (!m_seeded || bad) ? int'($urandom % MOD) : nxt(m_prev, m_dir);
            step(v, m, c, clr);
            if (i == 300) do_reset("reset_midstream");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Hardware checker at the output end of the up/down counter; consumes the counter's `count` and `mod` signals.
- Predicts each next count value, flags mismatches, and detects wrap-around events.
- Asserts a lock indication after a run of correct samples and keeps a saturating error tally.
- Instantiated alongside the counter in the top level; usable as an on-chip self-check and as a bench reference.

Parameters:
- WIDTH, 4, counter width in bits; arithmetic is modulo 2^WIDTH.
- LOCK_CNT, 4, consecutive matching samples required to assert locked (range 1..255).
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- vld  input  1  sample qualifier; count and mod are consumed only when vld=1.
- mod  input  1  counter direction; 1 = up, 0 = down.
- count  input  WIDTH  observed counter value.
- clr_err  input  1  synchronous clear of err_count.
- exp_count  output  WIDTH  predicted value of the next valid sample.
- mismatch  output  1  one-cycle pulse when a checked sample differs from the prediction.
- wrap  output  1  one-cycle pulse on a matched wrap (max->0 up, 0->max down).
- locked  output  1  high while in the LOCKED state.
- err_count  output  ERR_W  saturating mismatch count.

Behaviour:
- Reset (rst=0, asynchronous):
  - State -> SEED.
  - exp_count, mismatch, wrap, locked, err_count, match_run and mod_q all cleared to 0.
  - Release is synchronous to clk.
- Registers: model (WIDTH), mod_q (direction captured with the previous sample), match_run (8 bit), state.
- States:
  - SEED: on vld, model <= count, mod_q <= mod, go TRACK. No compare, no pulses.
  - TRACK: on vld, compare. Match -> match_run+1; when match_run reaches LOCK_CNT, go LOCKED. Mismatch -> match_run <= 0, stay TRACK.
  - LOCKED: on vld, compare. Match -> stay. Mismatch -> match_run <= 0, go TRACK, locked drops on the next cycle.
- Prediction:
  - pred = model+1 if mod_q=1, model-1 if mod_q=0, truncated to WIDTH bits.
  - The direction used is the one captured with the previous sample, because the counter applies mod on the following edge.
  - exp_count = pred (registered state, combinational decode); reads 0 in SEED.
- Compare, every vld in TRACK/LOCKED:
  - model <= count always (resync on mismatch); mod_q <= mod.
  - mismatch registered, high the cycle after the sample, exactly 1 cycle per bad sample. Latency 1.
  - err_count += 1 on mismatch, saturating at 2^ERR_W-1.
- wrap, registered with 1-cycle latency, asserted only on a matched sample where:
  - mod_q=1, model=2^WIDTH-1, count=0; or
  - mod_q=0, model=0, count=2^WIDTH-1.
- vld=0: all state held; mismatch and wrap are 0 that cycle.
- clr_err:
  - Clears err_count to 0 on the next edge.
  - If a mismatch occurs in the same cycle, the clear wins: result is 0, but the mismatch pulse still fires.
  - Does not affect the state machine.
- Direction change:
  - A mod change is legal at any sample and causes no mismatch if the counter follows it.
  - Example (WIDTH=4): samples 5(mod=1), 6(mod=0), then 5 is a match.
- LOCK_CNT=1: the first matching sample after SEED locks.
- Reset mid-operation: immediate return to SEED; the next vld sample reseeds with no mismatch.

Test Plan (WIDTH=4, LOCK_CNT=4, ERR_W=8):
- Reset release, vld=1, mod=1, count 0,1,2,3,4,5 -> no mismatch; locked=1 the cycle after sample 4; exp_count=6 after sample 5.
- Up wrap: count 13,14,15,0,1 with mod=1 -> single wrap pulse the cycle after sample 0; no mismatch. Down wrap: 2,1,0,15 with mod=0 -> wrap pulse after 15.
- While locked, inject 7,8,11,12 -> mismatch pulse after 11 only; err_count=1; locked drops; after 12 then three more correct samples, locked reasserts.
- Direction flip: 5(mod=1), 6(mod=0), 5, 4 -> no mismatch; exp_count=3 after sample 4.
- vld gaps: samples 3,4 then vld=0 for 5 cycles with count garbage, then 5 -> no mismatch, state held.
- Force 300 mismatches -> err_count saturates at 255. Assert clr_err in the same cycle as a mismatch -> err_count=0, mismatch pulse still high. Pull rst low mid-stream -> all outputs 0 immediately.
